// File: rtl/icache_fill_ctrl_pkg.sv
// Shared fill-controller definitions: block geometry and FSM encoding.
// Included by all icache_fill_ctrl files.
package icache_fill_ctrl_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFFSET_W = $clog2(WORDS_PER_BLOCK) + 1;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_META = 2'd2
  } fill_state_e;

endpackage

// File: rtl/icache_fill_ctrl_counter.sv
// Building blocks: write-enabled sync-reset DFF and the saturating
// word counter used for request issue and response receive.
module pldff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge clk) begin
    if (rst) o_q <= '0;
    else if (i_en) o_q <= i_d;
  end

endmodule

module fill_word_counter
  import icache_fill_ctrl_pkg::*;
#(
  parameter int W   = OFFSET_W,
  parameter int MAX = WORDS_PER_BLOCK
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_done
);

  localparam logic [W-1:0] MAXV = W'(MAX);

  logic [W-1:0] w_cnt;
  logic [W-1:0] w_nxt;
  logic         w_ld;

  assign o_done = (w_cnt == MAXV);
  assign w_ld   = i_clr | (i_en & ~o_done);
  assign w_nxt  = i_clr ? '0 : w_cnt + 1'b1;
  assign o_cnt  = w_cnt;

  pldff #(.W(W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_ld),
    .i_d  (w_nxt),
    .o_q  (w_cnt)
  );

endmodule

// File: rtl/icache_fill_ctrl.sv
// I-cache block fill controller: 8 in-order reads, stream to cache, meta pulse.
// Optional ICACHE_FILL_PERF_EN adds fill_count / stall_cycles outputs.
module icache_fill_ctrl
  import icache_fill_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = WORDS_PER_BLOCK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] missed_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_data_valid,
  output logic              cache_wen,
  output logic [DATA_W-1:0] cache_data,
  output logic              metadata_wen,
  output logic              fill_busy
`ifdef ICACHE_FILL_PERF_EN
  ,
  output logic [15:0]       fill_count,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int OFF_W = $clog2(WORDS) + 1;
  localparam int TAG_W = ADDR_W - OFF_W;

  logic [1:0]       w_state_q;
  fill_state_e      w_state;
  fill_state_e      w_state_nxt;
  logic [TAG_W-1:0] r_base;
  logic [OFF_W-1:0] w_issue_cnt;
  logic [OFF_W-1:0] w_recv_cnt;
  logic             w_issue_done;
  logic             w_recv_done;
  logic             w_idle;
  logic             w_run;
  logic             w_meta;
  logic             w_start;
  logic             w_rd_en;
  logic             w_wen;
  logic             w_last;
  logic             w_unused_lo;

  assign w_state = fill_state_e'(w_state_q);
  assign w_idle  = (w_state == FILL_IDLE);
  assign w_run   = (w_state == FILL_RUN);
  assign w_meta  = (w_state == FILL_META);
  assign w_start = w_idle & miss_detected;

  // Responses are only meaningful once a request has gone out
  assign w_rd_en = w_run & ~w_issue_done;
  assign w_wen   = w_run & mem_data_valid & ~w_recv_done
                 & (w_issue_cnt != '0);
  assign w_last  = (w_recv_cnt == OFF_W'(WORDS - 1));

  assign w_unused_lo = &missed_addr[OFF_W-1:0];

  always_comb begin
    w_state_nxt = w_state;
    unique case (1'b1)
      w_idle:  if (miss_detected) w_state_nxt = FILL_RUN;
      w_run:   if (w_wen && w_last) w_state_nxt = FILL_META;
      w_meta:  w_state_nxt = FILL_IDLE;
      default: w_state_nxt = FILL_IDLE;
    endcase
  end

  pldff #(.W(2)) u_state (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_d  (w_state_nxt),
    .o_q  (w_state_q)
  );

  pldff #(.W(TAG_W)) u_base (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_start),
    .i_d  (missed_addr[ADDR_W-1:OFF_W]),
    .o_q  (r_base)
  );

  fill_word_counter #(.W(OFF_W), .MAX(WORDS)) u_issue (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start),
    .i_en   (w_rd_en),
    .o_cnt  (w_issue_cnt),
    .o_done (w_issue_done)
  );

  fill_word_counter #(.W(OFF_W), .MAX(WORDS)) u_recv (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start),
    .i_en   (w_wen),
    .o_cnt  (w_recv_cnt),
    .o_done (w_recv_done)
  );

  // Offset is concatenated, so the block never carries into the tag
  assign mem_rd_en    = w_rd_en;
  assign mem_addr     = w_rd_en
                      ? {r_base, w_issue_cnt[OFF_W-2:0], 1'b0}
                      : '0;
  assign cache_wen    = w_wen;
  assign cache_data   = w_wen ? mem_data : '0;
  assign metadata_wen = w_meta;
  assign fill_busy    = ~w_idle;

`ifdef ICACHE_FILL_PERF_EN
  logic [15:0] r_fill_count;
  logic [15:0] r_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill_count <= '0;
      r_stall      <= '0;
    end else begin
      if (w_meta) r_fill_count <= r_fill_count + 16'd1;
      if (!w_idle && r_stall != 16'hFFFF)
        r_stall <= r_stall + 16'd1;
    end
  end

  assign fill_count   = r_fill_count;
  assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Scoreboard bench for icache_fill_ctrl: timed expectation queues
// built from the fill rules, checked by a negedge monitor.
module tb_icache_fill_ctrl;

  logic        clk;
  logic        rst;
  logic        miss_detected;
  logic [15:0] missed_addr;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_data_valid;
  logic        cache_wen;
  logic [15:0] cache_data;
  logic        metadata_wen;
  logic        fill_busy;
`ifdef ICACHE_FILL_PERF_EN
  logic [15:0] fill_count;
  logic [15:0] stall_cycles;
`endif

  icache_fill_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .miss_detected  (miss_detected),
    .missed_addr    (missed_addr),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_data_valid (mem_data_valid),
    .cache_wen      (cache_wen),
    .cache_data     (cache_data),
    .metadata_wen   (metadata_wen),
    .fill_busy      (fill_busy)
`ifdef ICACHE_FILL_PERF_EN
    ,
    .fill_count     (fill_count),
    .stall_cycles   (stall_cycles)
`endif
  );

  typedef struct {
    int          cyc;
    logic [15:0] val;
  } ev_t;

  ev_t qreq[$];
  ev_t qwr[$];
  ev_t qmeta[$];
  ev_t resp[$];

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          fs = 1;
  int          busy_until = 0;
  int          lat = 1;
  logic [15:0] salt = 16'h0;
  bit          mon_en = 0;
  bit          stray_en = 0;
  int          pf = 0;
  int          ps = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [15:0] hw(input logic [15:0] a,
                                     input logic [15:0] s);
    return (a * 16'h9E37) ^ s ^ {a[7:0], a[15:8]};
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory: responses in order after lat cycles, plus idle strays
  always @(posedge clk) begin
    #2;
    mem_data_valid = 1'b0;
    mem_data       = 16'h0;
    if (resp.size() > 0 && resp[0].cyc == cyc) begin
      mem_data_valid = 1'b1;
      mem_data       = resp[0].val;
      void'(resp.pop_front());
    end else if (stray_en && resp.size() == 0 &&
                 (cyc > busy_until || cyc == fs) &&
                 $urandom_range(0, 3) == 0) begin
      mem_data_valid = 1'b1;
      mem_data       = 16'($urandom);
    end
  end

  always @(negedge clk) begin
    bit er, ew, em, eb;
    if (mon_en) begin
      er = qreq.size() > 0 && qreq[0].cyc == cyc;
      ew = qwr.size() > 0 && qwr[0].cyc == cyc;
      em = qmeta.size() > 0 && qmeta[0].cyc == cyc;
      eb = cyc >= fs && cyc <= busy_until;
      chk("fill_busy", 32'(fill_busy), 32'(eb));
      chk("mem_rd_en", 32'(mem_rd_en), 32'(er));
      if (er && mem_rd_en)
        chk("mem_addr", 32'(mem_addr), 32'(qreq[0].val));
      if (er) void'(qreq.pop_front());
      if (mem_rd_en)
        resp.push_back('{cyc + lat, hw(mem_addr, salt)});
      chk("cache_wen", 32'(cache_wen), 32'(ew));
      if (ew && cache_wen)
        chk("cache_data", 32'(cache_data), 32'(qwr[0].val));
      if (ew) void'(qwr.pop_front());
      chk("metadata_wen", 32'(metadata_wen), 32'(em));
      if (em) void'(qmeta.pop_front());
      if (rst) begin
        pf = 0;
        ps = 0;
      end else begin
        if (eb && ps < 65535) ps++;
        if (em) pf = (pf + 1) & 16'hFFFF;
      end
    end
  end

  task automatic start_fill(input logic [15:0] a, input int l);
    logic [15:0] base;
    int c0;
    lat  = l;
    salt = 16'($urandom);
    base = a & 16'hFFF0;
    c0   = cyc;
    for (int i = 0; i < 8; i++) begin
      qreq.push_back('{c0 + 1 + i, base + 16'(2 * i)});
      qwr.push_back('{c0 + 1 + l + i, hw(base + 16'(2 * i), salt)});
    end
    qmeta.push_back('{c0 + 9 + l, 16'h0});
    fs            = c0 + 1;
    busy_until    = c0 + 9 + l;
    miss_detected = 1'b1;
    missed_addr   = a;
  endtask

  task automatic fill(input logic [15:0] a, input int l,
                      input int hold, input bit chg);
    start_fill(a, l);
    tick;
    repeat (hold) begin
      missed_addr = chg ? 16'h8000 : 16'($urandom);
      tick;
    end
    miss_detected = 1'b0;
    while (cyc <= busy_until) tick;
    repeat ($urandom_range(0, 2)) tick;
  endtask

  task automatic do_reset;
    int c;
    c = cyc;
    while (qreq.size() > 0 && qreq[$].cyc > c) void'(qreq.pop_back());
    while (qwr.size() > 0 && qwr[$].cyc > c) void'(qwr.pop_back());
    while (qmeta.size() > 0 && qmeta[$].cyc > c)
      void'(qmeta.pop_back());
    busy_until = c;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    miss_detected = 1'b0;
    missed_addr   = 16'h0;
    mem_data      = 16'h0;
    mem_data_valid = 1'b0;
    tick;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wen", 32'(cache_wen), 0);
    chk("rst_cdata", 32'(cache_data), 0);
    chk("rst_meta", 32'(metadata_wen), 0);
    chk("rst_busy", 32'(fill_busy), 0);
    tick;
    rst = 1'b0;

    // hits only, with stray responses that must be ignored
    stray_en = 1'b1;
    repeat (20) tick;

    fill(16'h1236, 4, 0, 1'b0);
    fill(16'hFFFA, 4, 2, 1'b0);
    fill(16'($urandom), 4, 0, 1'b0);
`ifdef ICACHE_FILL_PERF_EN
    chk("fill_count3", 32'(fill_count), 3);
    chk("stall39", 32'(stall_cycles), 39);
`endif

    fill(16'h4562, 3, 6, 1'b1);

    // abort a fill mid-flight
    start_fill(16'h2A4C, 4);
    tick;
    miss_detected = 1'b0;
    repeat (5) tick;
    do_reset;
    repeat (10) tick;

    for (int n = 0; n < 30; n++)
      fill(16'($urandom), $urandom_range(1, 6),
           $urandom_range(0, 7), 1'($urandom));

    repeat (10) tick;
    chk("drain", 32'(qreq.size() + qwr.size() + qmeta.size()), 0);
`ifdef ICACHE_FILL_PERF_EN
    chk("fill_count", 32'(fill_count), 32'(pf));
    chk("stall_cycles", 32'(stall_cycles), 32'(ps));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
